// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg
// Shared definitions for the oversampling ADC sequencer:
//   - seq_state_t   : sequencer FSM states
//   - ACC_EXTRA_W   : accumulator headroom bits above the ADC width
//   - OSR_SEL_MAX   : largest meaningful OSR select (256 conversions)
//   - osr_clamp()   : folds out-of-range OSR selects onto OSR_SEL_MAX
//   - osr_count()   : number of conversions for a clamped OSR select
package adc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_OUT,
        ST_NEXT
    } seq_state_t;

    // 256 samples of a full-scale code need 8 extra bits.
    localparam int ACC_EXTRA_W = 8;

    localparam logic [2:0] OSR_SEL_MAX = 3'd4;

    // Sample counter width: must hold 256.
    localparam int OSR_CNT_W = 9;

    localparam logic [OSR_CNT_W-1:0] OSR_ONE = 9'd1;

    function automatic logic [2:0] osr_clamp(input logic [2:0] sel);
        return (sel > OSR_SEL_MAX) ? OSR_SEL_MAX : sel;
    endfunction

    // OSR = 4**sel for a clamped select (1, 4, 16, 64, 256).
    function automatic logic [OSR_CNT_W-1:0] osr_count(input logic [2:0] sel_c);
        return OSR_ONE << {sel_c, 1'b0};
    endfunction

endpackage

// File: rtl/adc_seq_sync.sv
// adc_seq_sync
// Brings the ADC's conv_done level into the clk domain through two flops and
// produces a one-cycle pulse on each synchronized rising edge.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (all flops to 0)
//   async_i   : asynchronous level from the ADC macro
//   rise_o    : one-cycle pulse, high in the cycle after the 2nd sync stage
//               first sees the new high level
module adc_seq_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);

    // [0],[1]: synchronizer stages; [2]: previous value of stage [1].
    logic [2:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], async_i};
        end
    end

    assign rise_o = sync_reg[1] & ~sync_reg[2];

endmodule

// File: rtl/adc_osr_seq.sv
// adc_osr_seq
// Multi-channel SAR ADC conversion sequencer with oversampling averaging.
// Scans the latched channel mask from the lowest enabled channel upwards,
// runs OSR conversions per channel, and presents the truncated average on a
// valid/ready result port.
// Parameters: NCH (channels, 1..16), DATA_W (ADC width), TIMEOUT_CYC.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   start_i        : begin a round (only looked at in IDLE)
//   cont_i         : continuous mode, looked at when a round ends
//   osr_sel_i      : OSR select 0..4 -> 1..256, 5..7 treated as 4
//   ch_mask_i      : enabled channels
//   start_conv_o   : one-cycle conversion start pulse to the ADC
//   ch_sel_o       : analog mux select
//   conv_done_i    : ADC finished (asynchronous level)
//   adc_data_i     : ADC result, stable while conv_done_i is high
//   res_valid_o / res_ready_i / res_data_o / res_ch_o : result handshake
//   busy_o         : sequencer not idle
//   timeout_o      : sticky conversion-timeout flag
// Build option: define ADC_SEQ_TIMEOUT_EN to abort a conversion that gets no
// done edge within TIMEOUT_CYC cycles (channel skipped, timeout_o set).
// Without it WAIT waits forever and timeout_o is a constant 0.
module adc_osr_seq
    import adc_seq_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 1024,
    localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              cont_i,
    input  logic [2:0]        osr_sel_i,
    input  logic [NCH-1:0]    ch_mask_i,
    output logic              start_conv_o,
    output logic [CH_W-1:0]   ch_sel_o,
    input  logic              conv_done_i,
    input  logic [DATA_W-1:0] adc_data_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [DATA_W-1:0] res_data_o,
    output logic [CH_W-1:0]   res_ch_o,
    output logic              busy_o,
    output logic              timeout_o
);

    localparam int ACC_W = DATA_W + ACC_EXTRA_W;

    seq_state_t             state_reg;
    logic [NCH-1:0]         mask_reg;
    logic [2:0]             osr_reg;
    logic [CH_W-1:0]        ch_reg;
    logic [ACC_W-1:0]       acc_reg;
    logic [OSR_CNT_W-1:0]   cnt_reg;
    logic                   start_conv_reg;
    logic                   res_valid_reg;
    logic [DATA_W-1:0]      res_data_reg;
    logic [CH_W-1:0]        res_ch_reg;
    logic                   busy_reg;

    logic                   done_rise;
    logic [ACC_W-1:0]       acc_sum;
    logic [OSR_CNT_W-1:0]   cnt_inc;
    logic [NCH-1:0]         above_mask;
    logic [CH_W-1:0]        next_ch;
    logic                   next_found;

    adc_seq_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (conv_done_i),
        .rise_o  (done_rise)
    );

    // Lowest set bit of a channel mask (0 when the mask is empty).
    function automatic logic [CH_W-1:0] lowest_ch(input logic [NCH-1:0] m);
        logic [CH_W-1:0] ch;
        ch = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) begin
                ch = CH_W'(i);
            end
        end
        return ch;
    endfunction

    // Enabled channels strictly above the current one; the lowest of these
    // is the next channel of the round.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_above
            assign above_mask[gi] = mask_reg[gi] && (CH_W'(gi) > ch_reg);
        end
    endgenerate

    assign next_found = |above_mask;
    assign next_ch    = lowest_ch(above_mask);
    assign acc_sum    = acc_reg + ACC_W'(adc_data_i);
    assign cnt_inc    = cnt_reg + 1'b1;

`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              timeout_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            mask_reg       <= '0;
            osr_reg        <= '0;
            ch_reg         <= '0;
            acc_reg        <= '0;
            cnt_reg        <= '0;
            start_conv_reg <= 1'b0;
            res_valid_reg  <= 1'b0;
            res_data_reg   <= '0;
            res_ch_reg     <= '0;
            busy_reg       <= 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
            wait_cnt_reg   <= '0;
            timeout_reg    <= 1'b0;
`endif
        end else begin
            start_conv_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_i && (|ch_mask_i)) begin
                        mask_reg       <= ch_mask_i;
                        osr_reg        <= osr_clamp(osr_sel_i);
                        ch_reg         <= lowest_ch(ch_mask_i);
                        acc_reg        <= '0;
                        cnt_reg        <= '0;
                        start_conv_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                        state_reg      <= ST_START;
`ifdef ADC_SEQ_TIMEOUT_EN
                        timeout_reg    <= 1'b0;
`endif
                    end
                end

                // start_conv_o is already high for this cycle.
                ST_START: begin
                    state_reg <= ST_WAIT;
`ifdef ADC_SEQ_TIMEOUT_EN
                    wait_cnt_reg <= '0;
`endif
                end

                ST_WAIT: begin
                    if (done_rise) begin
                        acc_reg <= acc_sum;
                        cnt_reg <= cnt_inc;
                        if (cnt_inc < osr_count(osr_reg)) begin
                            // Go straight to the next conversion pulse.
                            start_conv_reg <= 1'b1;
                            state_reg      <= ST_START;
                        end else begin
                            // Average = sum / 4**sel, truncated to DATA_W.
                            res_data_reg  <= DATA_W'(acc_sum >> {osr_reg, 1'b0});
                            res_ch_reg    <= ch_reg;
                            res_valid_reg <= 1'b1;
                            state_reg     <= ST_OUT;
                        end
                    end
`ifdef ADC_SEQ_TIMEOUT_EN
                    else if (wait_cnt_reg == WAIT_W'(TIMEOUT_CYC - 1)) begin
                        // Abandon this channel; NEXT clears the partial sum.
                        timeout_reg <= 1'b1;
                        state_reg   <= ST_NEXT;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
`endif
                end

                ST_OUT: begin
                    if (res_valid_reg && res_ready_i) begin
                        res_valid_reg <= 1'b0;
                        state_reg     <= ST_NEXT;
                    end
                end

                ST_NEXT: begin
                    acc_reg <= '0;
                    cnt_reg <= '0;
                    if (next_found) begin
                        ch_reg         <= next_ch;
                        start_conv_reg <= 1'b1;
                        state_reg      <= ST_START;
                    end else if (cont_i) begin
                        // New round with the configuration latched at start.
                        ch_reg         <= lowest_ch(mask_reg);
                        start_conv_reg <= 1'b1;
                        state_reg      <= ST_START;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign start_conv_o = start_conv_reg;
    assign ch_sel_o     = ch_reg;
    assign res_valid_o  = res_valid_reg;
    assign res_data_o   = res_data_reg;
    assign res_ch_o     = res_ch_reg;
    assign busy_o       = busy_reg;

`ifdef ADC_SEQ_TIMEOUT_EN
    assign timeout_o = timeout_reg;
`else
    // Timeout logic is compiled out; the flag is constant 0 for any usable
    // TIMEOUT_CYC.
    assign timeout_o = 1'b0 & (TIMEOUT_CYC == 0);
`endif

endmodule

// File: tb/tb_adc_osr_seq.sv
`timescale 1ns/1ps
module tb_adc_osr_seq;

    localparam int TAB_N = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        cont_i = 1'b0;
    logic [2:0]  osr_sel_i = '0;
    logic [3:0]  ch_mask_i = '0;
    logic        start_conv_o;
    logic [1:0]  ch_sel_o;
    logic        conv_done_i = 1'b0;
    logic [15:0] adc_data_i = '0;
    logic        res_valid_o;
    logic        res_ready_i = 1'b0;
    logic [15:0] res_data_o;
    logic [1:0]  res_ch_o;
    logic        busy_o;
    logic        timeout_o;

    always #5 clk = ~clk;

    adc_osr_seq #(.NCH(4), .DATA_W(16), .TIMEOUT_CYC(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .cont_i       (cont_i),
        .osr_sel_i    (osr_sel_i),
        .ch_mask_i    (ch_mask_i),
        .start_conv_o (start_conv_o),
        .ch_sel_o     (ch_sel_o),
        .conv_done_i  (conv_done_i),
        .adc_data_i   (adc_data_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_data_o   (res_data_o),
        .res_ch_o     (res_ch_o),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Sample values the stub ADC returns, indexed by global conversion number.
    logic [15:0] data_tab [TAB_N];

    // ---------------- stub ADC ----------------
    int          adc_delay   = 10;
    int          stall_ch    = -1;
    bit          manual_mode = 1'b0;
    logic        manual_done = 1'b0;
    logic [15:0] manual_data = '0;
    int          conv_idx    = 0;
    int          start_cnt   = 0;
    int          dly_cnt     = 0;
    int          hold_cnt    = 0;
    logic [15:0] pend_data   = '0;

    initial begin : adc_stub
        forever begin
            @(negedge clk);
            if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) conv_done_i = 1'b0;
            end
            if (dly_cnt > 0) begin
                dly_cnt--;
                if (dly_cnt == 0) begin
                    adc_data_i  = pend_data;
                    conv_done_i = 1'b1;
                    hold_cnt    = 4;
                end
            end
            if (start_conv_o === 1'b1) begin
                start_cnt++;
                pend_data = data_tab[conv_idx % TAB_N];
                conv_idx++;
                if (!manual_mode && int'(ch_sel_o) != stall_ch) dly_cnt = adc_delay;
            end
            if (manual_mode) begin
                conv_done_i = manual_done;
                adc_data_i  = manual_data;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        vec_cnt++;
        err_cnt++;
        $display("FAIL %s: %s", name, why);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          ch;
        logic [15:0] data;
    } res_t;

    res_t exp_q[$];

    function automatic int popcount4(input logic [3:0] m);
        int n = 0;
        for (int i = 0; i < 4; i++) if (m[i]) n++;
        return n;
    endfunction

    function automatic int osr_of(input logic [2:0] sel);
        int e = (sel > 3'd4) ? 4 : int'(sel);
        return 4 ** e;
    endfunction

    // Each round visits enabled channels in ascending order; each channel
    // consumes osr consecutive samples and reports floor(mean).
    task automatic build_expect(input logic [3:0] mask, input logic [2:0] osr,
                                input int rounds, input int base);
        int   n = osr_of(osr);
        int   idx = base;
        res_t r;
        for (int rd = 0; rd < rounds; rd++) begin
            for (int c = 0; c < 4; c++) begin
                if (mask[c]) begin
                    longint sum = 0;
                    for (int k = 0; k < n; k++) begin
                        sum += longint'(data_tab[idx % TAB_N]);
                        idx++;
                    end
                    r.ch   = c;
                    r.data = 16'(sum / n);
                    exp_q.push_back(r);
                end
            end
        end
    endtask

    // kind: 0 const 1122, 1 repeating 100/200/300/400, 2 random,
    //       3 const FFFF, 4 const 0ABC, 5 const 0555
    task automatic fill_data(input int kind);
        for (int i = 0; i < TAB_N; i++) begin
            int j = (conv_idx + i) % TAB_N;
            case (kind)
                0:       data_tab[j] = 16'h1122;
                1:       data_tab[j] = 16'(100 * ((i % 4) + 1));
                2:       data_tab[j] = 16'($urandom);
                3:       data_tab[j] = 16'hFFFF;
                4:       data_tab[j] = 16'h0ABC;
                default: data_tab[j] = 16'h0555;
            endcase
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (res_valid_o !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (res_valid_o !== 1'b1) fail_now(name, "no res_valid_o within budget");
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy_o !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy_o !== 1'b0) fail_now(name, "busy_o did not drop within budget");
    endtask

    // One full sequencer run driven from the table or the random loop.
    task automatic run_case(input string tag, input logic [3:0] mask, input logic [2:0] osr,
                            input int rounds, input bit rdy_rand, input int kind,
                            input int exp_res, input int exp_starts,
                            input bit chk0, input logic [15:0] data0);
        int   starts0, nen, accepted, budget, cyc;
        bit   first;
        res_t e;
        fill_data(kind);
        starts0 = start_cnt;
        nen     = popcount4(mask);
        exp_q.delete();
        build_expect(mask, osr, (mask == 4'b0) ? 0 : rounds, conv_idx);
        @(negedge clk);
        ch_mask_i   = mask;
        osr_sel_i   = osr;
        cont_i      = (rounds > 1);
        res_ready_i = !rdy_rand;
        start_i     = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check({tag, "/busy_n1"}, busy_o, (mask != 4'b0));
        check({tag, "/start_n1"}, start_conv_o, (mask != 4'b0));
        // Mid-round configuration changes must be ignored.
        ch_mask_i = 4'($urandom);
        osr_sel_i = 3'($urandom);
        accepted = 0;
        first    = 1'b1;
        budget   = exp_starts * 24 + 200;
        for (cyc = 0; cyc < budget; cyc++) begin
            if (accepted == exp_res && busy_o === 1'b0) break;
            if (rdy_rand) res_ready_i = 1'($urandom_range(0, 1));
            if (res_valid_o === 1'b1 && res_ready_i === 1'b1) begin
                if (exp_q.size() == 0) begin
                    fail_now({tag, "/extra"}, "unexpected result");
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "/data"}, res_data_o, e.data);
                    check({tag, "/ch"}, res_ch_o, e.ch);
                    if (first && chk0) check({tag, "/data0"}, res_data_o, data0);
                    first = 1'b0;
                end
                accepted++;
                if (accepted > (rounds - 1) * nen) cont_i = 1'b0;
            end
            @(negedge clk);
        end
        if (cyc >= budget) fail_now({tag, "/budget"}, "run did not finish");
        check({tag, "/n_res"}, accepted, exp_res);
        check({tag, "/n_start"}, start_cnt - starts0, exp_starts);
        check({tag, "/idle"}, busy_o, 1'b0);
        check({tag, "/timeout"}, timeout_o, 1'b0);
        res_ready_i = 1'b0;
        cont_i      = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- stimulus table ----------------
    typedef struct {
        logic [3:0]  mask;
        logic [2:0]  osr;
        int          rounds;
        bit          rdy_rand;
        int          kind;
        int          exp_res;
        int          exp_starts;
        bit          chk0;
        logic [15:0] data0;
    } vec_t;

    vec_t tab [7];

    initial begin : main
        int          s0, n;
        bit          stable, seen;
        logic [3:0]  rmask;
        logic [2:0]  rosr;
        int          rr;

        tab[0] = '{4'b0101, 3'd0, 1, 1'b0, 0, 2,  2,   1'b1, 16'h1122};
        tab[1] = '{4'b0001, 3'd1, 1, 1'b0, 1, 1,  4,   1'b1, 16'd250};
        tab[2] = '{4'b1000, 3'd4, 1, 1'b0, 3, 1,  256, 1'b1, 16'hFFFF};
        tab[3] = '{4'b1111, 3'd0, 3, 1'b1, 2, 12, 12,  1'b0, 16'h0};
        tab[4] = '{4'b0110, 3'd2, 1, 1'b1, 2, 2,  32,  1'b0, 16'h0};
        tab[5] = '{4'b0010, 3'd6, 1, 1'b0, 2, 1,  256, 1'b0, 16'h0};
        tab[6] = '{4'b0000, 3'd0, 1, 1'b0, 0, 0,  0,   1'b0, 16'h0};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset/start_conv", start_conv_o, 1'b0);
        check("reset/res_valid", res_valid_o, 1'b0);
        check("reset/busy", busy_o, 1'b0);
        check("reset/res_data", res_data_o, 16'h0);
        check("reset/ch_sel", ch_sel_o, 2'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_case($sformatf("tab%0d", i), tab[i].mask, tab[i].osr, tab[i].rounds,
                     tab[i].rdy_rand, tab[i].kind, tab[i].exp_res, tab[i].exp_starts,
                     tab[i].chk0, tab[i].data0);
            $display("vector tab%0d mask=%b osr=%0d rounds=%0d done", i, tab[i].mask,
                     tab[i].osr, tab[i].rounds);
        end

        // Backpressure: result held, no new conversion, next channel at M+2.
        fill_data(4);
        @(negedge clk);
        ch_mask_i = 4'b0011; osr_sel_i = 3'd0; cont_i = 1'b0; res_ready_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_valid("bp/first", 100);
        s0 = start_cnt;
        stable = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (!(res_valid_o === 1'b1 && res_data_o === 16'h0ABC && res_ch_o === 2'd0
                  && start_conv_o === 1'b0)) stable = 1'b0;
        end
        check("bp/hold", stable, 1'b1);
        check("bp/no_start", start_cnt - s0, 0);
        check("bp/data", res_data_o, 16'h0ABC);
        res_ready_i = 1'b1;
        @(negedge clk);
        check("bp/valid_low", res_valid_o, 1'b0);
        check("bp/no_start_m1", start_conv_o, 1'b0);
        @(negedge clk);
        check("bp/start_m2", start_conv_o, 1'b1);
        check("bp/ch_sel_m2", ch_sel_o, 2'd1);
        wait_valid("bp/second", 100);
        check("bp/ch2", res_ch_o, 2'd1);
        @(negedge clk);
        check("bp/busy_m1", busy_o, 1'b1);
        @(negedge clk);
        check("bp/idle_m2", busy_o, 1'b0);
        res_ready_i = 1'b0;
        $display("vector backpressure done");

        // A done level already high at start must not count.
        manual_data = 16'h0321;
        manual_done = 1'b1;
        manual_mode = 1'b1;
        repeat (5) @(negedge clk);
        ch_mask_i = 4'b0001; osr_sel_i = 3'd0; res_ready_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid_o === 1'b1) seen = 1'b1;
        end
        check("held/no_result", seen, 1'b0);
        check("held/busy", busy_o, 1'b1);
        manual_done = 1'b0;
        repeat (4) @(negedge clk);
        manual_done = 1'b1;
        wait_valid("held/result", 20);
        check("held/data", res_data_o, 16'h0321);
        wait_idle("held/idle", 20);
        manual_done = 1'b0;
        repeat (2) @(negedge clk);
        manual_mode = 1'b0;
        res_ready_i = 1'b0;
        $display("vector held_done done");

        // Reset during WAIT, then a late done must do nothing.
        fill_data(0);
        @(negedge clk);
        ch_mask_i = 4'b0100; osr_sel_i = 3'd0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        check("rst/pre_ch", ch_sel_o, 2'd2);
        #2 rst = 1'b1;
        #1;
        check("rst/busy", busy_o, 1'b0);
        check("rst/ch_sel", ch_sel_o, 2'd0);
        check("rst/res_data", res_data_o, 16'h0);
        check("rst/start_conv", start_conv_o, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        res_ready_i = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (res_valid_o !== 1'b0 || busy_o !== 1'b0) seen = 1'b1;
        end
        check("rst/quiet", seen, 1'b0);
        res_ready_i = 1'b0;
        $display("vector reset_mid_wait done");

`ifdef ADC_SEQ_TIMEOUT_EN
        // Channel 1 never finishes: skipped after 64 WAIT cycles.
        fill_data(5);
        stall_ch = 1;
        @(negedge clk);
        ch_mask_i = 4'b0110; osr_sel_i = 3'd0; res_ready_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        seen = 1'b0;
        while (timeout_o !== 1'b1 && n < 200) begin
            if (res_valid_o === 1'b1) seen = 1'b1;
            @(negedge clk);
            n++;
        end
        check("to/flag", timeout_o, 1'b1);
        check("to/window", (n >= 60 && n <= 75), 1'b1);
        check("to/no_ch1", seen, 1'b0);
        wait_valid("to/ch2", 100);
        check("to/ch2_ch", res_ch_o, 2'd2);
        check("to/ch2_data", res_data_o, 16'h0555);
        wait_idle("to/idle", 20);
        check("to/sticky", timeout_o, 1'b1);
        stall_ch = -1;
        @(negedge clk);
        ch_mask_i = 4'b0100;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("to/cleared", timeout_o, 1'b0);
        wait_idle("to/idle2", 100);
        res_ready_i = 1'b0;
        $display("vector timeout done");
`endif

        // Randomized runs against the model.
        for (int i = 0; i < 6; i++) begin
            rmask = 4'($urandom_range(1, 15));
            rosr  = 3'($urandom_range(0, 2));
            rr    = $urandom_range(1, 2);
            run_case($sformatf("rnd%0d", i), rmask, rosr, rr, 1'b1, 2,
                     rr * popcount4(rmask), rr * popcount4(rmask) * osr_of(rosr),
                     1'b0, 16'h0);
            $display("vector rnd%0d mask=%b osr=%0d rounds=%0d done", i, rmask, rosr, rr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/adc_osr_seq.md
# adc_osr_seq

Synthesizable multi-channel conversion sequencer with oversampling averaging, driving the SAR ADC macro's start/finished interface from the digital user area. It scans an enabled-channel mask, issues 1..256 conversions per channel, accumulates and averages the results, and hands each averaged sample to the host over a valid/ready port. It replaces firmware-driven polling of `start_conversion` / `conversion_finished`.

## Interface
- `NCH`, 4: number of analog channels, 1..16.
- `DATA_W`, 16: ADC result width.
- `TIMEOUT_CYC`, 1024: conversion timeout in `clk` cycles. Used only with `ADC_SEQ_TIMEOUT_EN`.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start_i` in 1: begin a round. Sampled only in IDLE.
- `cont_i` in 1: continuous mode. Sampled at each round end.
- `osr_sel_i` in 3: OSR select. 0..4 selects 1, 4, 16, 64, 256; 5..7 clamp to 256.
- `ch_mask_i` in NCH: enabled channels.
- `start_conv_o` out 1: one-cycle start pulse to the ADC.
- `ch_sel_o` out clog2(NCH): analog mux select.
- `conv_done_i` in 1: ADC conversion finished. Asynchronous to `clk`.
- `adc_data_i` in DATA_W: ADC result. Stable while `conv_done_i` is high.
- `res_valid_o` out 1: result valid.
- `res_ready_i` in 1: host ready.
- `res_data_o` out DATA_W: averaged result.
- `res_ch_o` out clog2(NCH): channel of `res_data_o`.
- `busy_o` out 1: sequencer not in IDLE.
- `timeout_o` out 1: sticky timeout flag.

## Operation
- **Reset values.** All outputs 0; FSM in IDLE; accumulator and sample counter 0.
- **IDLE**
  - On `start_i`=1 with `ch_mask_i`≠0: latch `osr_sel_i` and `ch_mask_i`, select the lowest enabled channel, clear the accumulator, go to START.
  - `start_i` with an all-zero mask is ignored.
- **START.** Assert `start_conv_o` for exactly one cycle, then go to WAIT.
- **WAIT**
  - `conv_done_i` passes through a 2-FF synchronizer followed by a rising-edge detector.
  - On a detected rising edge: add `adc_data_i` to the accumulator and increment the sample counter.
  - If the counter is below the OSR, go to START; otherwise go to OUT.
- **OUT**
  - Load `res_data_o` = acc >> (2·osr_sel), truncating.
  - Load `res_ch_o` = current channel and set `res_valid_o`=1.
  - Hold all three until `res_valid_o && res_ready_i`; the FSM stalls while `res_ready_i`=0 (backpressure, no data loss). Then go to NEXT.
- **NEXT**
  - Move to the next higher enabled channel and go to START, clearing the accumulator and counter.
  - After the highest enabled channel, the round ends:
    - `cont_i`=1: restart at the lowest enabled channel, using the same latched config.
    - `cont_i`=0: go to IDLE.
- **Arithmetic.** Accumulator is unsigned, DATA_W+8 bits; 256 × max(DATA_W) cannot overflow. The averaged result is exactly DATA_W bits.
- **Stability.** `ch_sel_o` changes only in NEXT/IDLE transitions and is stable throughout all conversions of a channel.
- **Config changes.** Changes to `osr_sel_i`/`ch_mask_i` mid-round take effect only at the next `start_i` from IDLE.
- **Held done level.** A `conv_done_i` still high from a previous conversion does not count; only rising edges count.
- **Reset mid-operation.** Immediately returns to IDLE with all outputs 0; the pending result is discarded.

## Timing
- `start_i` sampled at edge N → `start_conv_o` high in cycle N+1 and `busy_o`=1 from N+1.
- `conv_done_i` rising edge → accumulation at the 3rd `clk` edge after it (2 synchronizer stages plus edge detect).
- Accumulation → next `start_conv_o` in the following cycle.
- Last accumulation → `res_valid_o` high in the following cycle.
- Handshake completes at edge M → `res_valid_o` low in cycle M+1; next `start_conv_o` in cycle M+2, or `busy_o`=0 in M+2 when returning to IDLE.

## Configuration
- Macro: `ADC_SEQ_TIMEOUT_EN`.
- **Defined:**
  - A WAIT-state counter aborts a conversion when no rising edge arrives within `TIMEOUT_CYC` cycles.
  - On abort: set `timeout_o`, discard the channel's accumulation, produce no result for that channel, proceed as NEXT.
  - `timeout_o` clears on the next accepted `start_i`.
- **Undefined:** WAIT waits indefinitely; `timeout_o` is tied to 0.

## Structure
- Package `adc_seq_pkg`:
  - FSM state enum (IDLE, START, WAIT, OUT, NEXT).
  - OSR encoding constants and the osr_sel clamp function.
  - `ACC_EXTRA_W`=8.
- Sub-module `adc_seq_sync`: 2-FF synchronizer plus rising-edge detector for `conv_done_i`, reset to 0.

## Test plan
- **Single round, no oversampling.** NCH=4, mask=4'b0101, osr_sel=0; stub ADC returns 16'h1122 with done 10 cycles after start → two results (ch0, ch2), each 16'h1122; then IDLE, busy_o=0.
- **OSR averaging.** osr_sel=1, ADC returns 100, 200, 300, 400 → exactly 4 start pulses, res_data_o=250. osr_sel=4 with constant 16'hFFFF → 256 pulses, result 16'hFFFF (no overflow).
- **Backpressure.** res_ready_i=0 for 50 cycles → res_valid_o, res_data_o and res_ch_o hold; no start_conv_o issued; after ready, the next channel starts 2 cycles later.
- **Continuous mode and edge cases.** cont_i=1 for 3 rounds, then deasserted → sequencer stops after the current round. start_i with mask=0 → stays IDLE.
- **Reset mid-WAIT.** rst pulse during WAIT → all outputs 0 asynchronously; a late conv_done_i afterwards produces no accumulation.
- **Timeout (`ADC_SEQ_TIMEOUT_EN`, TIMEOUT_CYC=64).** ADC never raises done on ch1 → timeout_o=1 after 64 cycles, ch1 result skipped, ch2 result delivered; next start_i clears timeout_o.
